// File: rtl/target_score_tracker.sv
// ============================================================================
// target_score_tracker: places pseudo-random targets on the grid during GAME,
// detects head-on-target hits and keeps a saturating 4-bit score.
// Revision: 1.0
// ============================================================================
`default_nettype none

module target_score_tracker #(
   parameter int unsigned X_CELLS = 160,
   parameter int unsigned Y_CELLS = 120,
   parameter logic [7:0]  X_SEED  = 8'hA5,
   parameter logic [6:0]  Y_SEED  = 7'h3B,
   parameter logic [7:0]  X_INIT  = 8'd80,
   parameter logic [6:0]  Y_INIT  = 7'd60
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] MSM_STATE,
   input  logic [7:0] HEAD_X,
   input  logic [6:0] HEAD_Y,
   output logic [7:0] TARGET_X,
   output logic [6:0] TARGET_Y,
   output logic [3:0] SCORE,
   output logic       TARGET_HIT
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PLACE  = 2'd1;
   localparam logic [1:0] S_ACTIVE = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   localparam logic [1:0] c_MSM_GAME = 2'd1;
   localparam logic [1:0] c_MSM_WIN  = 2'd2;

   localparam logic [8:0] c_X_LIM = 9'(X_CELLS);
   localparam logic [7:0] c_Y_LIM = 8'(Y_CELLS);

   logic [1:0] state_q, state_d;
   logic [7:0] lfsr_x_q, lfsr_x_d;
   logic [6:0] lfsr_y_q, lfsr_y_d;
   logic [7:0] tgt_x_q, tgt_x_d;
   logic [6:0] tgt_y_q, tgt_y_d;
   logic [3:0] score_q, score_d;
   logic       hit_q, hit_d;

   logic       w_msm_idle;
   logic       w_sample_ok;
   logic       w_on_target;

   // MSM value 3 is unused and behaves exactly like IDLE
   assign w_msm_idle  = (MSM_STATE != c_MSM_GAME) && (MSM_STATE != c_MSM_WIN);
   assign w_sample_ok = ({1'b0, lfsr_x_q} < c_X_LIM) && ({1'b0, lfsr_y_q} < c_Y_LIM)
                        && !((lfsr_x_q == HEAD_X) && (lfsr_y_q == HEAD_Y));
   assign w_on_target = (HEAD_X == tgt_x_q) && (HEAD_Y == tgt_y_q);

   always_comb begin
      lfsr_x_d = {lfsr_x_q[6:0], lfsr_x_q[7] ^ lfsr_x_q[5] ^ lfsr_x_q[4] ^ lfsr_x_q[3]};
      lfsr_y_d = {lfsr_y_q[5:0], lfsr_y_q[6] ^ lfsr_y_q[5]};
      state_d  = state_q;
      tgt_x_d  = tgt_x_q;
      tgt_y_d  = tgt_y_q;
      score_d  = score_q;
      hit_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            score_d = 4'd0;
            if (MSM_STATE == c_MSM_GAME) begin
               state_d = S_PLACE;
            end
         end
         S_PLACE: begin
            if (w_msm_idle) begin
               state_d = S_IDLE;
               score_d = 4'd0;
            end else if (MSM_STATE == c_MSM_WIN) begin
               state_d = S_HOLD;
            end else if (w_sample_ok) begin
               tgt_x_d = lfsr_x_q;
               tgt_y_d = lfsr_y_q;
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            // Leaving GAME overrides a coincident hit: no score, no pulse
            if (w_msm_idle) begin
               state_d = S_IDLE;
               score_d = 4'd0;
            end else if (MSM_STATE == c_MSM_WIN) begin
               state_d = S_HOLD;
            end else if (w_on_target) begin
               score_d = (score_q == 4'hF) ? score_q : score_q + 4'd1;
               hit_d   = 1'b1;
               state_d = S_PLACE;
            end
         end
         S_HOLD: begin
            if (w_msm_idle) begin
               state_d = S_IDLE;
               score_d = 4'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q  <= S_IDLE;
         lfsr_x_q <= X_SEED;
         lfsr_y_q <= Y_SEED;
         tgt_x_q  <= X_INIT;
         tgt_y_q  <= Y_INIT;
         score_q  <= 4'd0;
         hit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_x_q <= lfsr_x_d;
         lfsr_y_q <= lfsr_y_d;
         tgt_x_q  <= tgt_x_d;
         tgt_y_q  <= tgt_y_d;
         score_q  <= score_d;
         hit_q    <= hit_d;
      end
   end

   assign TARGET_X   = tgt_x_q;
   assign TARGET_Y   = tgt_y_q;
   assign SCORE      = score_q;
   assign TARGET_HIT = hit_q;

endmodule

`default_nettype wire

// File: tb/tb_target_score_tracker.sv
// ============================================================================
// tb_target_score_tracker: directed-vector bench for target_score_tracker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_target_score_tracker;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [1:0] MSM_STATE = 2'd0;
   logic [7:0] HEAD_X = 8'd0;
   logic [6:0] HEAD_Y = 7'd0;
   logic [7:0] TARGET_X;
   logic [6:0] TARGET_Y;
   logic [3:0] SCORE;
   logic       TARGET_HIT;

   int n_vec = 0;
   int n_err = 0;

   target_score_tracker dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .MSM_STATE  (MSM_STATE),
      .HEAD_X     (HEAD_X),
      .HEAD_Y     (HEAD_Y),
      .TARGET_X   (TARGET_X),
      .TARGET_Y   (TARGET_Y),
      .SCORE      (SCORE),
      .TARGET_HIT (TARGET_HIT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] nx(input logic [7:0] x);
      return {x[6:0], ^(x & 8'b1011_1000)};
   endfunction

   function automatic logic [6:0] ny(input logic [6:0] y);
      return {y[5:0], y[6] ^ y[5]};
   endfunction

   // Reference copy of both LFSRs, tracking the DUT's reset and free-run
   logic [7:0] m_x;
   logic [6:0] m_y;
   always @(posedge CLK) begin
      if (!RESET) begin
         m_x <= 8'hA5;
         m_y <= 7'h3B;
      end else begin
         m_x <= nx(m_x);
         m_y <= ny(m_y);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      @(negedge CLK);
   endtask

   // Called just after the edge that entered PLACE; predicts the latched pair
   task automatic place_and_check(input string tag, output int k);
      logic [7:0] x;
      logic [6:0] y;
      logic       found;
      x = m_x;
      y = m_y;
      found = 1'b0;
      k = 0;
      for (int i = 0; i < 300; i++) begin
         if (!found) begin
            if (x < 8'd160 && y < 7'd120 && !(x == HEAD_X && y == HEAD_Y)) begin
               found = 1'b1;
               k = i;
            end else begin
               x = nx(x);
               y = ny(y);
            end
         end
      end
      chk({tag, "_found"}, {31'd0, found}, 32'd1);
      tick(k + 1);
      chk({tag, "_tx"}, {24'd0, TARGET_X}, {24'd0, x});
      chk({tag, "_ty"}, {25'd0, TARGET_Y}, {25'd0, y});
   endtask

   task automatic do_hit(input int exp_score);
      int k;
      HEAD_X = TARGET_X;
      HEAD_Y = TARGET_Y;
      tick(1);
      chk("hit_pulse", {31'd0, TARGET_HIT}, 32'd1);
      chk("hit_score", {28'd0, SCORE}, exp_score);
      place_and_check("retarget", k);
      chk("hit_once", {31'd0, TARGET_HIT}, 32'd0);
      tick(1);
      chk("score_held", {28'd0, SCORE}, exp_score);
      chk("no_pulse", {31'd0, TARGET_HIT}, 32'd0);
   endtask

   initial begin
      int k;
      logic [7:0] keep_x;
      logic [6:0] keep_y;

      tick(2);
      chk("rst_score", {28'd0, SCORE}, 32'd0);
      chk("rst_tx", {24'd0, TARGET_X}, 32'd80);
      chk("rst_ty", {25'd0, TARGET_Y}, 32'd60);
      chk("rst_hit", {31'd0, TARGET_HIT}, 32'd0);

      RESET = 1'b1;
      tick(10);
      chk("idle_score", {28'd0, SCORE}, 32'd0);
      chk("idle_tx", {24'd0, TARGET_X}, 32'd80);
      chk("idle_ty", {25'd0, TARGET_Y}, 32'd60);
      chk("idle_hit", {31'd0, TARGET_HIT}, 32'd0);

      // 255 edges after release the X LFSR is back at 0xA5 (165): first sample rejected
      tick(244);
      MSM_STATE = 2'd1;
      tick(1);
      place_and_check("first", k);
      chk("first_retries", k, 32'd1);
      chk("first_tx_hand", {24'd0, TARGET_X}, 32'd74);
      chk("first_ty_hand", {25'd0, TARGET_Y}, 32'd110);

      do_hit(1);
      do_hit(2);
      do_hit(3);

      HEAD_X = TARGET_X;
      HEAD_Y = TARGET_Y;
      keep_x = TARGET_X;
      keep_y = TARGET_Y;
      MSM_STATE = 2'd2;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         chk("hold_hit", {31'd0, TARGET_HIT}, 32'd0);
      end
      chk("hold_score", {28'd0, SCORE}, 32'd3);
      chk("hold_tx", {24'd0, TARGET_X}, {24'd0, keep_x});
      chk("hold_ty", {25'd0, TARGET_Y}, {25'd0, keep_y});

      MSM_STATE = 2'd0;
      HEAD_X = 8'd0;
      HEAD_Y = 7'd0;
      tick(1);
      chk("hold_to_idle_score", {28'd0, SCORE}, 32'd0);
      MSM_STATE = 2'd1;
      tick(1);
      place_and_check("replace", k);

      HEAD_X = TARGET_X;
      HEAD_Y = TARGET_Y;
      keep_x = TARGET_X;
      MSM_STATE = 2'd0;
      tick(1);
      chk("ovr_hit", {31'd0, TARGET_HIT}, 32'd0);
      chk("ovr_score", {28'd0, SCORE}, 32'd0);
      tick(2);
      chk("ovr_idle_hit", {31'd0, TARGET_HIT}, 32'd0);
      chk("ovr_keep_tx", {24'd0, TARGET_X}, {24'd0, keep_x});
      chk("ovr_idle_score", {28'd0, SCORE}, 32'd0);

      HEAD_X = 8'd0;
      HEAD_Y = 7'd0;
      MSM_STATE = 2'd1;
      tick(1);
      place_and_check("regame", k);
      for (int s = 1; s <= 15; s++) begin
         do_hit(s);
      end
      do_hit(15);

      HEAD_X = TARGET_X;
      HEAD_Y = TARGET_Y;
      RESET = 1'b0;
      tick(1);
      chk("rsthit_score", {28'd0, SCORE}, 32'd0);
      chk("rsthit_hit", {31'd0, TARGET_HIT}, 32'd0);
      chk("rsthit_tx", {24'd0, TARGET_X}, 32'd80);
      chk("rsthit_ty", {25'd0, TARGET_Y}, 32'd60);

      // Seeds reloaded: first PLACE sample is one step past the seeds, (74,119)
      RESET = 1'b1;
      HEAD_X = 8'd0;
      HEAD_Y = 7'd0;
      tick(1);
      place_and_check("post_rst", k);
      chk("post_rst_tx_hand", {24'd0, TARGET_X}, 32'd74);
      chk("post_rst_ty_hand", {25'd0, TARGET_Y}, 32'd119);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
